// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a two-entry skid buffer. The ready path is registered.
// It also provides flush, hit-gated freeze and a saturating stall counter. State updates on the falling clock edge.
module id_ex_skid_reg #(
   parameter int DATA_W      = 16,
   parameter int REG_ADDR_W  = 3,
   parameter int CTRL_W      = 9,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   hit_in,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      adder_in,
   input  logic [DATA_W-1:0]      rd1_in,
   input  logic [DATA_W-1:0]      rd2_in,
   input  logic [DATA_W-1:0]      imm_in,
   input  logic [REG_ADDR_W-1:0]  rt_in,
   input  logic [REG_ADDR_W-1:0]  rd_in,
   input  logic [CTRL_W-1:0]      ctrl_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      adder_out,
   output logic [DATA_W-1:0]      rd1_out,
   output logic [DATA_W-1:0]      rd2_out,
   output logic [DATA_W-1:0]      imm_out,
   output logic [REG_ADDR_W-1:0]  rt_out,
   output logic [REG_ADDR_W-1:0]  rd_out,
   output logic [CTRL_W-1:0]      ctrl_out,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam int ENTRY_W = 4*DATA_W + 2*REG_ADDR_W + CTRL_W;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t               state;
   logic [ENTRY_W-1:0]   main_q;
   logic [ENTRY_W-1:0]   skid_q;
   logic [ENTRY_W-1:0]   in_entry;
   logic [CTRL_W-1:0]    main_ctrl;
   logic                 main_valid;
   logic                 skid_valid;
   logic                 accept;
   logic                 pop;
   logic                 stall_now;

   assign in_entry   = {adder_in, rd1_in, rd2_in, imm_in, rt_in, rd_in, ctrl_in};
   assign main_valid = (state != EMPTY);
   assign skid_valid = (state == FULL);

   assign in_ready  = hit_in & ~skid_valid;
   assign out_valid = hit_in & main_valid;
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign stall_now = main_valid & (~hit_in | ~out_ready) & ~flush;

   assign {adder_out, rd1_out, rd2_out, imm_out, rt_out, rd_out, main_ctrl} = main_q;
   assign ctrl_out = out_valid ? main_ctrl : '0;

   always_comb begin
      occupancy = 2'd0;
      case (state)
         EMPTY:   occupancy = 2'd0;
         ONE:     occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   // Leaving a valid state zeroes the main control bundle. The data fields are left stale.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         state                <= EMPTY;
         main_q[CTRL_W-1:0]   <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_q <= in_entry;
                  state  <= ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_q <= in_entry;
               end else if (accept) begin
                  skid_q <= in_entry;
                  state  <= FULL;
               end else if (pop) begin
                  main_q[CTRL_W-1:0] <= '0;
                  state              <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  main_q <= skid_q;
                  state  <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (stall_now && (stall_cnt != {STALL_CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed bench for id_ex_skid_reg. It drives a default-width instance and a 3-bit-counter instance in lockstep.
module tb_id_ex_skid_reg;

   logic        clk;
   logic        rst_n;
   logic        hit_in;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] adder_in, rd1_in, rd2_in, imm_in;
   logic [2:0]  rt_in, rd_in;
   logic [8:0]  ctrl_in;

   logic        in_ready, out_valid;
   logic [15:0] adder_out, rd1_out, rd2_out, imm_out;
   logic [2:0]  rt_out, rd_out;
   logic [8:0]  ctrl_out;
   logic [1:0]  occupancy;
   logic [15:0] stall_cnt;

   logic        s_in_ready, s_out_valid;
   logic [15:0] s_adder_out, s_rd1_out, s_rd2_out, s_imm_out;
   logic [2:0]  s_rt_out, s_rd_out;
   logic [8:0]  s_ctrl_out;
   logic [1:0]  s_occupancy;
   logic [2:0]  s_stall_cnt;

   int compared   = 0;
   int mismatched = 0;

   id_ex_skid_reg dut (
      .clk(clk), .rst_n(rst_n), .hit_in(hit_in), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .adder_in(adder_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
      .rt_in(rt_in), .rd_in(rd_in), .ctrl_in(ctrl_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .adder_out(adder_out), .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
      .rt_out(rt_out), .rd_out(rd_out), .ctrl_out(ctrl_out),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   id_ex_skid_reg #(.STALL_CNT_W(3)) dut_sat (
      .clk(clk), .rst_n(rst_n), .hit_in(hit_in), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .adder_in(adder_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
      .rt_in(rt_in), .rd_in(rd_in), .ctrl_in(ctrl_in),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .adder_out(s_adder_out), .rd1_out(s_rd1_out), .rd2_out(s_rd2_out), .imm_out(s_imm_out),
      .rt_out(s_rt_out), .rd_out(s_rd_out), .ctrl_out(s_ctrl_out),
      .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   // The DUT updates on the falling edge, so outputs are sampled 2 time units after it.
   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [8:0] c);
      in_valid = v;
      adder_in = a;
      rd1_in   = ~a;
      rd2_in   = a ^ 16'h5555;
      imm_in   = {a[14:0], 1'b1};
      rt_in    = a[6:4];
      rd_in    = ~a[6:4];
      ctrl_in  = c;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_n = 1'b0; hit_in = 1'b1; flush = 1'b0; out_ready = 1'b1;
      applyStimulus(1'b0, 16'h0000, 9'h000);

      // 1: reset, then a full-throughput stream
      repeat (2) tick();
      checkOutput("rst_occ", occupancy, 0);
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_adder", adder_out, 0);
      checkOutput("rst_rd1", rd1_out, 0);
      checkOutput("rst_ctrl", ctrl_out, 0);
      checkOutput("rst_stall", stall_cnt, 0);
      rst_n = 1'b1;
      #1 checkOutput("rel_in_ready", in_ready, 1);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 16'(i), 9'h1A3);
         tick();
         checkOutput($sformatf("stream_adder%0d", i), adder_out, i);
         checkOutput($sformatf("stream_ctrl%0d", i), ctrl_out, 9'h1A3);
         checkOutput($sformatf("stream_occ%0d", i), occupancy, 1);
         checkOutput($sformatf("stream_rdy%0d", i), in_ready, 1);
      end
      checkOutput("stream_rd1", rd1_out, 16'hFFFA);
      checkOutput("stream_rd", rd_out, 3'b111);
      applyStimulus(1'b0, 16'h0000, 9'h000);
      tick();
      checkOutput("drain_occ", occupancy, 0);
      checkOutput("drain_valid", out_valid, 0);
      checkOutput("drain_ctrl", ctrl_out, 0);
      checkOutput("stream_stall", stall_cnt, 0);

      // 2: backpressure
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'h0010, 9'h0A1); tick();
      applyStimulus(1'b1, 16'h0020, 9'h0A2); tick();
      checkOutput("bp_occ_full", occupancy, 2);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_head_a", adder_out, 16'h0010);
      applyStimulus(1'b1, 16'h0030, 9'h0A3); tick();
      checkOutput("bp_hold_a", adder_out, 16'h0010);
      checkOutput("bp_hold_occ", occupancy, 2);
      checkOutput("bp_ctrl_a", ctrl_out, 9'h0A1);
      out_ready = 1'b1;
      tick();
      checkOutput("bp_out_b", adder_out, 16'h0020);
      checkOutput("bp_ctrl_b", ctrl_out, 9'h0A2);
      checkOutput("bp_occ_one", occupancy, 1);
      tick();
      checkOutput("bp_out_c", adder_out, 16'h0030);
      checkOutput("bp_imm_c", imm_out, 16'h0061);
      applyStimulus(1'b0, 16'h0000, 9'h000); tick();
      checkOutput("bp_empty", occupancy, 0);
      checkOutput("bp_stall", stall_cnt, 2);

      // 3: freeze while full
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'h0040, 9'h0B1); tick();
      applyStimulus(1'b1, 16'h0050, 9'h0B2); tick();
      checkOutput("fz_full", occupancy, 2);
      hit_in = 1'b0; out_ready = 1'b1;
      applyStimulus(1'b1, 16'h0060, 9'h0B3);
      #1;
      checkOutput("fz_out_valid", out_valid, 0);
      checkOutput("fz_in_ready", in_ready, 0);
      checkOutput("fz_ctrl", ctrl_out, 0);
      repeat (4) tick();
      checkOutput("fz_hold_adder", adder_out, 16'h0040);
      checkOutput("fz_hold_occ", occupancy, 2);
      checkOutput("fz_stall", stall_cnt, 7);
      hit_in = 1'b1;
      tick();
      checkOutput("fz_resume_e", adder_out, 16'h0050);
      tick();
      checkOutput("fz_resume_f", adder_out, 16'h0060);
      checkOutput("fz_resume_ctrl", ctrl_out, 9'h0B3);
      applyStimulus(1'b0, 16'h0000, 9'h000); tick();
      checkOutput("fz_empty", occupancy, 0);
      checkOutput("fz_stall_after", stall_cnt, 7);

      // 4: flush with a simultaneous incoming entry
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'h0070, 9'h0C1); tick();
      applyStimulus(1'b1, 16'h0080, 9'h0C2); tick();
      checkOutput("fl_full", occupancy, 2);
      flush = 1'b1; out_ready = 1'b1;
      applyStimulus(1'b1, 16'h0099, 9'h0C3); tick();
      checkOutput("fl_occ", occupancy, 0);
      checkOutput("fl_valid", out_valid, 0);
      checkOutput("fl_ctrl", ctrl_out, 0);
      flush = 1'b0;
      applyStimulus(1'b0, 16'h0000, 9'h000); tick();
      checkOutput("fl_no_99", adder_out, 16'h0070);
      checkOutput("fl_occ_after", occupancy, 0);
      checkOutput("fl_stall", stall_cnt, 8);

      // 5: asynchronous reset between edges while full
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'h00A0, 9'h0D1); tick();
      applyStimulus(1'b1, 16'h00B0, 9'h0D2); tick();
      checkOutput("ar_full", occupancy, 2);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("ar_occ", occupancy, 0);
      checkOutput("ar_adder", adder_out, 0);
      checkOutput("ar_valid", out_valid, 0);
      checkOutput("ar_stall", stall_cnt, 0);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      applyStimulus(1'b1, 16'h00C0, 9'h0D3); tick();
      checkOutput("ar_first", adder_out, 16'h00C0);
      checkOutput("ar_first_ctrl", ctrl_out, 9'h0D3);
      checkOutput("ar_first_occ", occupancy, 1);
      applyStimulus(1'b0, 16'h0000, 9'h000); tick();
      checkOutput("ar_drain", occupancy, 0);

      // 6: stall counter saturation on the 3-bit instance
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'h00D0, 9'h0E1); tick();
      applyStimulus(1'b0, 16'h0000, 9'h000);
      repeat (6) tick();
      checkOutput("sat_mid", s_stall_cnt, 6);
      repeat (4) tick();
      checkOutput("sat_top", s_stall_cnt, 7);
      checkOutput("sat_wide", stall_cnt, 10);
      checkOutput("sat_head", s_adder_out, 16'h00D0);
      out_ready = 1'b1; tick();
      checkOutput("sat_drain", s_occupancy, 0);
      checkOutput("sat_hold", s_stall_cnt, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
